// File: rtl/pt2262_pkg.sv
// Shared definitions for the PT2262 transmit path: trit codes, scheduler states, defaults.
package pt2262_pkg;

  // Two-bit pin codes of a coded address
  localparam logic [1:0] TRIT_0   = 2'b00;
  localparam logic [1:0] TRIT_1   = 2'b11;
  localparam logic [1:0] TRIT_F   = 2'b01;
  localparam logic [1:0] TRIT_BAD = 2'b10;

  localparam int unsigned DEF_REPEATS = 4;
  localparam int unsigned DEF_GAP_CYC = 384;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    GAP
  } sched_state_t;

  // True when any of the 8 pins of a coded address carries the illegal code
  function automatic logic addr_has_bad(input logic [15:0] addr);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (addr[2*i +: 2] == TRIT_BAD) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/pt2262_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module pt2262_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic             valid
);

  // Scan requesters in priority order starting at ptr; first hit wins
  always_comb begin
    logic [PTR_W-1:0] k;
    gnt   = '0;
    valid = 1'b0;
    k     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = PTR_W'((32'(ptr) + i) % N_REQ);
      if (!valid && req[k]) begin
        gnt[k] = 1'b1;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pt2262_tx_scheduler.sv
// Shares one PT2262 encoder among N_REQ requesters: round-robin grant, latch of the
// winner's address/data, REPEATS codewords per grant, then an idle gap.
module pt2262_tx_scheduler
  import pt2262_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned REPEATS = DEF_REPEATS,
  parameter int unsigned GAP_CYC = DEF_GAP_CYC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ*16-1:0] addr_i,
  input  logic [N_REQ*4-1:0] data_i,
  output logic [N_REQ-1:0]   grant_o,
  output logic [N_REQ-1:0]   ack_o,
  output logic [N_REQ-1:0]   err_o,
  output logic               enc_en_o,
  output logic [15:0]        enc_addr_o,
  output logic [3:0]         enc_data_o,
  input  logic               enc_word_done_i,
  output logic               busy_o
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned WW = $clog2(REPEATS + 1);
  // A zero gap still needs a legal one-bit counter; it is never used then
  localparam int unsigned GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  localparam logic [WW-1:0] LAST_WORD = WW'(REPEATS - 1);
  localparam logic [GW-1:0] LAST_GAP  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [PW-1:0] LAST_REQ  = PW'(N_REQ - 1);

  sched_state_t     state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    cur_idx;
  logic [WW-1:0]    word_cnt;
  logic [GW-1:0]    gap_cnt;

  logic [N_REQ-1:0] pick_gnt;
  logic             pick_valid;
  logic [15:0]      win_addr;
  logic [3:0]       win_data;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    next_ptr;

  pt2262_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PW)
  ) u_pick (
    .req   (req_i),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // Select the winner's address, data and index from the one-hot grant
  always_comb begin
    win_addr = '0;
    win_data = '0;
    win_idx  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (pick_gnt[k]) begin
        win_addr = addr_i[16*k +: 16];
        win_data = data_i[4*k +: 4];
        win_idx  = PW'(k);
      end
    end
  end

  // Pointer moves just past the requester being retired
  always_comb begin
    next_ptr = (cur_idx == LAST_REQ) ? '0 : cur_idx + 1'b1;
  end

  assign busy_o = (state != IDLE);

  // Scheduler FSM with all handshake and encoder outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur_idx    <= '0;
      word_cnt   <= '0;
      gap_cnt    <= '0;
      grant_o    <= '0;
      ack_o      <= '0;
      err_o      <= '0;
      enc_en_o   <= 1'b0;
      enc_addr_o <= '0;
      enc_data_o <= '0;
    end else begin
      ack_o <= '0;
      err_o <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_o    <= pick_gnt;
            enc_addr_o <= win_addr;
            enc_data_o <= win_data;
            cur_idx    <= win_idx;
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (addr_has_bad(enc_addr_o)) begin
            err_o   <= grant_o;
            grant_o <= '0;
            rr_ptr  <= next_ptr;
            state   <= IDLE;
          end else begin
            enc_en_o <= 1'b1;
            word_cnt <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (enc_word_done_i) begin
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == LAST_WORD) begin
              enc_en_o <= 1'b0;
              ack_o    <= grant_o;
              grant_o  <= '0;
              rr_ptr   <= next_ptr;
              gap_cnt  <= '0;
              state    <= (GAP_CYC == 0) ? IDLE : GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == LAST_GAP) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pt2262_tx_scheduler.sv
// Randomized self-checking bench for pt2262_tx_scheduler. Two instances: the default
// configuration and a REPEATS=1 / GAP_CYC=0 corner; 'sel' routes stimulus and outputs.
module tb_pt2262_tx_scheduler;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] addr;
  logic [15:0] data;
  logic        wd;
  logic        sel;

  logic [3:0]  req_a, req_b, grant_a, grant_b, ack_a, ack_b, err_a, err_b;
  logic        wd_a, wd_b, en_a, en_b, busy_a, busy_b;
  logic [15:0] eaddr_a, eaddr_b;
  logic [3:0]  edata_a, edata_b;

  logic [3:0]  grant, ack, err, enc_data;
  logic        enc_en, busy;
  logic [15:0] enc_addr;

  assign req_a    = sel ? 4'b0 : req;
  assign req_b    = sel ? req : 4'b0;
  assign wd_a     = sel ? 1'b0 : wd;
  assign wd_b     = sel ? wd : 1'b0;
  assign grant    = sel ? grant_b : grant_a;
  assign ack      = sel ? ack_b : ack_a;
  assign err      = sel ? err_b : err_a;
  assign enc_en   = sel ? en_b : en_a;
  assign enc_addr = sel ? eaddr_b : eaddr_a;
  assign enc_data = sel ? edata_b : edata_a;
  assign busy     = sel ? busy_b : busy_a;

  pt2262_tx_scheduler #(.N_REQ(4), .REPEATS(4), .GAP_CYC(384)) dut_a (
    .clk(clk), .reset(reset), .req_i(req_a), .addr_i(addr), .data_i(data),
    .grant_o(grant_a), .ack_o(ack_a), .err_o(err_a), .enc_en_o(en_a),
    .enc_addr_o(eaddr_a), .enc_data_o(edata_a), .enc_word_done_i(wd_a), .busy_o(busy_a)
  );

  pt2262_tx_scheduler #(.N_REQ(4), .REPEATS(1), .GAP_CYC(0)) dut_b (
    .clk(clk), .reset(reset), .req_i(req_b), .addr_i(addr), .data_i(data),
    .grant_o(grant_b), .ack_o(ack_b), .err_o(err_b), .enc_en_o(en_b),
    .enc_addr_o(eaddr_b), .enc_data_o(edata_b), .enc_word_done_i(wd_b), .busy_o(busy_b)
  );

  always #5 clk = ~clk;

  int checks  = 0;
  int errors  = 0;
  int ptr     = 0;  // model round-robin pointer
  int rep_cur = 4;
  int gap_cur = 384;

  // Model: first pending requester at or after p, wrapping
  function automatic int pick(input logic [3:0] m, input int p);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (p + i) % N;
      if (m[k]) return k;
    end
    return -1;
  endfunction

  function automatic bit is_bad(input logic [15:0] a);
    for (int i = 0; i < 8; i++) if (a[2*i +: 2] == 2'b10) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] rand_addr(input bit bad, input int bad_pin);
    logic [15:0] a;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 2))
        0:       a[2*i +: 2] = 2'b00;
        1:       a[2*i +: 2] = 2'b11;
        default: a[2*i +: 2] = 2'b01;
      endcase
    end
    if (bad) a[2*bad_pin +: 2] = 2'b10;
    return a;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input bit now, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < 2000) begin
      tick();
      n++;
      if (grant !== 4'b0) break;
    end
    checks++;
    if (grant === 4'b0) begin
      errors++;
      $display("FAIL grant_timeout: no grant after %0d cycles, expected a grant", n);
    end else begin
      ok = 1'b1;
      if (now && n != 1) begin
        errors++;
        $display("FAIL grant_latency: grant after %0d cycles, expected 1", n);
      end
    end
    if (ok) begin
      checks++;
      if (ack !== 4'b0 || err !== 4'b0) begin
        errors++;
        $display("FAIL pulse_idle: ack=%b err=%b at grant, expected 0000/0000", ack, err);
      end
    end
  endtask

  // One grant cycle for requester k; abort_at>0 returns right after that word-done
  task automatic run_frame(input int k, input bit now, input bit mutate, input bit stray,
                           input int abort_at);
    logic [15:0] ea;
    logic [3:0]  ed, oh;
    bit          bad, ok, gap_bad;
    ea  = addr[16*k +: 16];
    ed  = data[4*k +: 4];
    oh  = 4'(1 << k);
    bad = is_bad(ea);
    wait_grant(now, ok);
    if (!ok) return;
    checks++;
    if (grant !== oh || busy !== 1'b1 || enc_en !== 1'b0) begin
      errors++;
      $display("FAIL grant: grant=%b busy=%b en=%b, expected grant=%b busy=1 en=0",
               grant, busy, enc_en, oh);
    end
    if (stray) wd = 1'b1;
    tick();
    wd = 1'b0;
    if (bad) begin
      checks++;
      if (err !== oh || grant !== 4'b0 || enc_en !== 1'b0 || ack !== 4'b0) begin
        errors++;
        $display("FAIL illegal: err=%b grant=%b en=%b ack=%b, expected err=%b others 0",
                 err, grant, enc_en, ack, oh);
      end
      req[k] = 1'b0;
      ptr    = (k + 1) % N;
      return;
    end
    checks++;
    if (enc_en !== 1'b1 || enc_addr !== ea || enc_data !== ed || err !== 4'b0) begin
      errors++;
      $display("FAIL load: en=%b addr=%h data=%h err=%b, expected en=1 addr=%h data=%h err=0",
               enc_en, enc_addr, enc_data, err, ea, ed);
    end
    if (mutate) begin
      req[k]            = 1'b0;
      addr[16*k +: 16]  = ~ea;
      data[4*k +: 4]    = ~ed;
    end
    for (int w = 1; w <= rep_cur; w++) begin
      repeat ($urandom_range(0, 3)) begin
        tick();
        checks++;
        if (enc_en !== 1'b1 || ack !== 4'b0 || enc_addr !== ea || enc_data !== ed) begin
          errors++;
          $display("FAIL send_hold: en=%b ack=%b addr=%h data=%h, expected 1/0000/%h/%h",
                   enc_en, ack, enc_addr, enc_data, ea, ed);
        end
      end
      wd = 1'b1;
      tick();
      wd = 1'b0;
      if (w == abort_at) return;
      checks++;
      if (w < rep_cur) begin
        if (enc_en !== 1'b1 || ack !== 4'b0 || grant !== oh) begin
          errors++;
          $display("FAIL word_%0d: en=%b ack=%b grant=%b, expected en=1 ack=0 grant=%b",
                   w, enc_en, ack, grant, oh);
        end
      end else begin
        if (ack !== oh || enc_en !== 1'b0 || grant !== 4'b0) begin
          errors++;
          $display("FAIL ack: ack=%b en=%b grant=%b, expected ack=%b en=0 grant=0",
                   ack, enc_en, grant, oh);
        end
      end
    end
    req[k] = 1'b0;
    ptr    = (k + 1) % N;
    gap_bad = 1'b0;
    for (int i = 1; i <= gap_cur; i++) begin
      tick();
      if (grant !== 4'b0 || (i == 1 && ack !== 4'b0) || busy !== (i < gap_cur)) gap_bad = 1'b1;
    end
    if (gap_cur > 0) begin
      checks++;
      if (gap_bad) begin
        errors++;
        $display("FAIL gap: grant/ack/busy wrong during %0d-cycle gap, expected idle gap",
                 gap_cur);
      end
    end
  endtask

  // Raise a set of simultaneous requests and follow the model's service order
  task automatic serve(input logic [3:0] mask, input bit mutate_rand);
    logic [3:0] pend;
    bit         now;
    int         k;
    pend = mask;
    now  = 1'b0;
    req  = mask;
    while (pend != 4'b0) begin
      k = pick(pend, ptr);
      run_frame(k, now, mutate_rand && ($urandom_range(0, 1) == 1), 1'b0, 0);
      pend[k] = 1'b0;
      now     = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req = '0; addr = '0; data = '0; wd = 1'b0; sel = 1'b0;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0 || ack !== 4'b0 || err !== 4'b0 || enc_en !== 1'b0 ||
        enc_addr !== 16'h0 || enc_data !== 4'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: grant=%b ack=%b err=%b en=%b addr=%h data=%h busy=%b, expected 0",
               grant, ack, err, enc_en, enc_addr, enc_data, busy);
    end
    reset = 1'b0;
    tick();
    ptr = 0;
  endtask

  task automatic test_all_four;
    for (int k = 0; k < N; k++) begin
      addr[16*k +: 16] = rand_addr(1'b0, 0);
      data[4*k +: 4]   = 4'($urandom);
    end
    serve(4'b1111, 1'b0);
  endtask

  task automatic test_single;
    addr[15:0] = 16'hFFFF;
    data[3:0]  = 4'hA;
    req        = 4'b0001;
    run_frame(pick(4'b0001, ptr), 1'b0, 1'b0, 1'b1, 0);
  endtask

  task automatic test_illegal;
    addr[47:32] = rand_addr(1'b1, 5);
    addr[63:48] = rand_addr(1'b0, 0);
    data[11:8]  = 4'h3;
    data[15:12] = 4'hC;
    serve(4'b1100, 1'b0);
  endtask

  task automatic test_mid_send_change;
    addr[31:16] = rand_addr(1'b0, 0);
    data[7:4]   = 4'h5;
    req         = 4'b0010;
    run_frame(pick(4'b0010, ptr), 1'b0, 1'b1, 1'b0, 0);
  endtask

  task automatic test_reset_mid_send;
    addr[47:32] = rand_addr(1'b0, 0);
    data[11:8]  = 4'h9;
    req         = 4'b0100;
    run_frame(pick(4'b0100, ptr), 1'b0, 1'b0, 1'b0, 2);
    reset = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0 || ack !== 4'b0 || err !== 4'b0 || enc_en !== 1'b0 ||
        enc_addr !== 16'h0 || enc_data !== 4'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: grant=%b ack=%b err=%b en=%b addr=%h data=%h busy=%b, expected 0",
               grant, ack, err, enc_en, enc_addr, enc_data, busy);
    end
    req = '0;
    tick();
    reset = 1'b0;
    ptr   = 0;
    addr[15:0]  = rand_addr(1'b0, 0);
    addr[63:48] = rand_addr(1'b0, 0);
    data[3:0]   = 4'h6;
    data[15:12] = 4'hE;
    serve(4'b1001, 1'b0);
  endtask

  task automatic test_random;
    repeat (5) begin
      logic [3:0] mask;
      mask = 4'($urandom_range(1, 15));
      for (int k = 0; k < N; k++) begin
        addr[16*k +: 16] = rand_addr($urandom_range(0, 3) == 0, $urandom_range(0, 7));
        data[4*k +: 4]   = 4'($urandom);
      end
      serve(mask, 1'b1);
    end
  endtask

  task automatic test_corner;
    req = '0;
    tick();
    sel     = 1'b1;
    rep_cur = 1;
    gap_cur = 0;
    ptr     = 0;
    for (int k = 0; k < N; k++) begin
      addr[16*k +: 16] = rand_addr(1'b0, 0);
      data[4*k +: 4]   = 4'($urandom);
    end
    serve(4'b0110, 1'b0);
    for (int k = 0; k < N; k++) begin
      addr[16*k +: 16] = rand_addr($urandom_range(0, 3) == 0, $urandom_range(0, 7));
      data[4*k +: 4]   = 4'($urandom);
    end
    serve(4'b1111, 1'b1);
  endtask

  initial begin
    test_reset();
    test_all_four();
    test_single();
    test_illegal();
    test_mid_send_change();
    test_reset_mid_send();
    test_random();
    test_corner();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
